// File: rtl/lm32_dp_ram_be_if.sv
// Bus bundle for lm32_dp_ram_be: write port, read port and clear control.
// The master side drives the requests and the slave side is the RAM.
interface lm32_dp_ram_be_if #(
    parameter int addr_width = 10,
    parameter int data_width = 32,
    parameter int byte_width = 8
);
    localparam int NB = data_width / byte_width;

    logic                  flush_i;
    logic                  busy_o;
    logic                  we_i;
    logic [NB-1:0]         be_i;
    logic [addr_width-1:0] waddr_i;
    logic [data_width-1:0] wdata_i;
    logic                  re_i;
    logic [addr_width-1:0] raddr_i;
    logic [data_width-1:0] rdata_o;

    modport master (
        output flush_i, we_i, be_i, waddr_i, wdata_i, re_i, raddr_i,
        input  busy_o, rdata_o
    );

    modport slave (
        input  flush_i, we_i, be_i, waddr_i, wdata_i, re_i, raddr_i,
        output busy_o, rdata_o
    );
endinterface

// File: rtl/lm32_dp_ram_be.sv
// Simple dual-port RAM with byte-lane write enables, a registered read port
// that holds its data when re_i is low, optional write-to-read bypass, and a
// clear sequencer that zeroes the whole array after reset or on flush_i.
module lm32_dp_ram_be #(
    parameter int addr_width = 10,
    parameter int addr_depth = 1024,
    parameter int data_width = 32,
    parameter int byte_width = 8,
    parameter bit bypass     = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    lm32_dp_ram_be_if.slave      bus
);
    localparam int NB = data_width / byte_width;
    // One extra bit so addr_depth == 2**addr_width is representable.
    localparam logic [addr_width:0]   DEPTH_W = (addr_width + 1)'(addr_depth);
    localparam logic [addr_width-1:0] LAST_A  = addr_width'(addr_depth - 1);
    localparam logic [addr_width-1:0] ONE_A   = addr_width'(1);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [addr_width-1:0] cnt_q, cnt_d;
    logic [addr_width-1:0] raddr_q, raddr_d;
    logic [data_width-1:0] rdata_q, rdata_d;
    logic [data_width-1:0] mem_q [0:addr_depth-1];

    logic                  wr_in_range_s;
    logic                  rd_in_range_s;
    logic                  mem_we_s;
    logic [addr_width-1:0] mem_addr_s;
    logic [data_width-1:0] mem_wdata_s;
    logic [NB-1:0]         mem_be_s;
    logic [addr_width-1:0] eff_addr_s;

    // Replace the enabled byte lanes of base with the matching lanes of wdat.
    function automatic logic [data_width-1:0] merge_lanes(
        input logic [data_width-1:0] base,
        input logic [data_width-1:0] wdat,
        input logic [NB-1:0]         be
    );
        logic [data_width-1:0] res;
        res = base;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                res[k*byte_width +: byte_width] = wdat[k*byte_width +: byte_width];
            end else begin
                res[k*byte_width +: byte_width] = base[k*byte_width +: byte_width];
            end
        end
        return res;
    endfunction

    assign wr_in_range_s = ({1'b0, bus.waddr_i} < DEPTH_W);
    assign rd_in_range_s = ({1'b0, bus.raddr_i} < DEPTH_W);
    assign eff_addr_s    = bus.re_i ? bus.raddr_i : raddr_q;

    // State and clear-counter registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: walk the clear counter to the last word, flush restarts it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (bus.flush_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (cnt_q == LAST_A) begin
                    state_d = READY;
                    cnt_d   = '0;
                end else begin
                    state_d = CLEAR;
                    cnt_d   = cnt_q + ONE_A;
                end
            end
            READY: begin
                if (bus.flush_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    state_d = READY;
                    cnt_d   = cnt_q;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Write-port selection: clear sequencer owns the port while clearing.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = bus.waddr_i;
        mem_wdata_s = bus.wdata_i;
        mem_be_s    = bus.be_i;
        case (state_q)
            CLEAR: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = cnt_q;
                mem_wdata_s = '0;
                mem_be_s    = {NB{1'b1}};
            end
            READY: begin
                // A flush cycle drops the user write; out-of-range writes too.
                mem_we_s    = bus.we_i & wr_in_range_s & ~bus.flush_i;
                mem_addr_s  = bus.waddr_i;
                mem_wdata_s = bus.wdata_i;
                mem_be_s    = bus.be_i;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_addr_s  = bus.waddr_i;
                mem_wdata_s = bus.wdata_i;
                mem_be_s    = bus.be_i;
            end
        endcase
    end

    // Storage array; no reset because the clear sequencer initialises it.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int k = 0; k < NB; k++) begin
                if (mem_be_s[k]) begin
                    mem_q[mem_addr_s][k*byte_width +: byte_width] <=
                        mem_wdata_s[k*byte_width +: byte_width];
                end
            end
        end
    end

    // Read-port next value: load, hold, and optional same-cycle write forwarding.
    always_comb begin
        rdata_d = rdata_q;
        raddr_d = raddr_q;
        if ((state_q == CLEAR) || bus.flush_i) begin
            rdata_d = '0;
            raddr_d = '0;
        end else begin
            if (bus.re_i) begin
                raddr_d = bus.raddr_i;
                rdata_d = rd_in_range_s ? mem_q[bus.raddr_i] : '0;
            end else begin
                raddr_d = raddr_q;
                rdata_d = rdata_q;
            end
            // The array read above is pre-write; merge this edge's write lanes.
            if (bypass && mem_we_s && (bus.waddr_i == eff_addr_s)) begin
                rdata_d = merge_lanes(rdata_d, bus.wdata_i, bus.be_i);
            end else begin
                rdata_d = rdata_d;
            end
        end
    end

    // Read data and held read address registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
            raddr_q <= '0;
        end else begin
            rdata_q <= rdata_d;
            raddr_q <= raddr_d;
        end
    end

    assign bus.busy_o  = (state_q == CLEAR);
    assign bus.rdata_o = rdata_q;

endmodule

// File: doc/lm32_dp_ram_be.md
# lm32_dp_ram_be

Parametrised simple dual-port RAM (one write port, one read port, single clock) for the LM32 caches, register file and MMU TLB arrays. It adds per-byte write enables and a registered read port with read-enable hold. An optional write-to-read bypass keeps the read data coherent with same-cycle writes. A built-in clear sequencer zeroes the whole array after reset or on request, so cache/TLB invalidation needs no external walker.

## Interface
- addr_width, 10, width of both address ports
- addr_depth, 1024, number of words; must be ≤ 2^addr_width
- data_width, 32, word width; must be a multiple of byte_width
- byte_width, 8, bits per write-enable lane; NB = data_width/byte_width
- bypass, 1, 1 = forward write data to read port on address match; 0 = read-old-data on collision
- clk_i  in  1  clock, all state on rising edge
- rst_n_i  in  1  reset, asynchronous and active-low
- flush_i  in  1  start (or restart) a full-array clear
- busy_o  out  1  clear sequencer running; write and read ports inactive
- we_i  in  1  write strobe
- be_i  in  NB  byte-lane enables, lane k = wdata_i[k*byte_width +: byte_width]
- waddr_i  in  addr_width  write address
- wdata_i  in  data_width  write data
- re_i  in  1  read enable; 1 = load new word, 0 = hold rdata_o
- raddr_i  in  addr_width  read address
- rdata_o  out  data_width  registered read data

## Operation
- FSM states: CLEAR, READY. Reset enters CLEAR with clear counter = 0.
- CLEAR: each cycle write all-zeros to ram[counter] and increment the counter. After writing addr_depth-1, go to READY. we_i, be_i and re_i are ignored. rdata_o is forced to 0. The held read address register resets to 0.
- flush_i = 1 in READY: go to CLEAR with counter = 0. The write port is ignored that same cycle.
- flush_i = 1 in CLEAR: the counter restarts at 0.
- READY write: when we_i = 1 and waddr_i < addr_depth, write lane k only where be_i[k] = 1. be_i = 0 is a no-op. waddr_i ≥ addr_depth is dropped.
- READY read, re_i = 1: load rdata_o with ram[raddr_i] as it was before this edge's write. raddr_i ≥ addr_depth yields 0. Register raddr_i as the held address.
- READY read, re_i = 0: rdata_o holds its value.
- Bypass (bypass = 1), applies when we_i = 1 and the write address equals the effective read address (raddr_i if re_i = 1, else the held address). Enabled lanes of rdata_o take wdata_i; other lanes take the array/held value. rdata_o therefore always equals the current array contents at the held address.
- Bypass off (bypass = 0): on collision rdata_o gets the old data. A held rdata_o is not updated by later writes.
- busy_o = 1 exactly while in CLEAR.

## Timing
- Reset values: busy_o = 1, rdata_o = 0, counter = 0, held address = 0, state CLEAR. Array contents are undefined until the clear completes.
- Clear timing: let edge 1 be the first rising edge after rst_n_i deasserts. Edge n writes address n-1. At edge addr_depth the state becomes READY and busy_o falls. Total busy time is addr_depth cycles. A flush gives the same count, measured from the edge that samples flush_i.
- Read latency: 1 cycle. Address is presented at edge t; data is valid after edge t.
- Write latency: visible to a read issued at the next edge. With bypass = 1 it is also visible in the same edge.
- Reset asserted mid-clear or mid-access: return immediately to the reset values. The clear restarts from address 0.
- Reads and writes are accepted starting at the first edge after busy_o is observed low.

## Test plan
- Reset release, addr_depth = 16: busy_o high for exactly 16 cycles. Then reads of addresses 0..15 return 0x00000000.
- Write 0xDEADBEEF to addr 5 with be_i = 4'b1111. Then write 0x000000AA with be_i = 4'b0001. Reading addr 5 returns 0xDEADBEAA.
- Same-cycle write 0x12345678, be 4'b1100, to addr 3 (currently 0xAAAAAAAA), with re_i = 1 and raddr_i = 3. bypass = 1 gives 0x1234AAAA; bypass = 0 gives 0xAAAAAAAA, and the following read gives 0x1234AAAA.
- Read addr 7 (0x11111111), then hold re_i = 0 and write 0xFFFFFFFF to addr 7. bypass = 1: rdata_o becomes 0xFFFFFFFF. bypass = 0: rdata_o stays 0x11111111.
- flush_i pulsed with array populated: busy_o high for addr_depth cycles, and a write issued mid-clear is dropped. Assert flush_i again mid-clear: the busy window restarts from that edge. Afterwards all reads return 0.
- rst_n_i pulsed low mid-write sequence: rdata_o = 0 and busy_o = 1 immediately (asynchronous). Out-of-range write to addr_depth is dropped, and a read of addr_depth returns 0.
